// File: rtl/fcb_3_skid_buffer_full_perf_no_comb_path.sv
// Valid/ready skid-buffer stage: one transfer per cycle, with every output driven straight from a flop.
// Because no output is combinational, there is no path from down_rdy to up_rdy or from up_vld to down_vld.
module fcb_3_skid_buffer_full_perf_no_comb_path #(
  parameter int unsigned w = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         up_vld,
  output logic         up_rdy,
  input  logic [w-1:0] up_data,
  output logic         down_vld,
  input  logic         down_rdy,
  output logic [w-1:0] down_data,
  output logic [1:0]   occupancy
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StBusy  = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic         down_vld_q, down_vld_d;
  logic         skid_vld_q, skid_vld_d;
  logic         up_rdy_q, up_rdy_d;
  logic [1:0]   occ_q, occ_d;
  logic [w-1:0] main_q, main_d;
  logic [w-1:0] skid_q, skid_d;
  logic         up_xfer;

  assign up_xfer = up_vld & up_rdy_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: begin
        if (up_xfer) state_d = StBusy;
      end
      StBusy: begin
        if (up_xfer && !down_rdy) begin
          state_d = StFull;
        end else if (!up_xfer && down_rdy) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (down_rdy) state_d = StBusy;
      end
      default: state_d = StEmpty;
    endcase
  end

  // Status flops are loaded from the next state so that each output comes directly from a flop.
  always_comb begin
    down_vld_d = 1'b0;
    skid_vld_d = 1'b0;
    up_rdy_d   = 1'b1;
    occ_d      = 2'd0;
    unique case (state_d)
      StEmpty: begin
        down_vld_d = 1'b0;
        skid_vld_d = 1'b0;
        up_rdy_d   = 1'b1;
        occ_d      = 2'd0;
      end
      StBusy: begin
        down_vld_d = 1'b1;
        skid_vld_d = 1'b0;
        up_rdy_d   = 1'b1;
        occ_d      = 2'd1;
      end
      StFull: begin
        down_vld_d = 1'b1;
        skid_vld_d = 1'b1;
        up_rdy_d   = 1'b0;
        occ_d      = 2'd2;
      end
      default: begin
        down_vld_d = 1'b0;
        skid_vld_d = 1'b0;
        up_rdy_d   = 1'b1;
        occ_d      = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      down_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      up_rdy_q   <= 1'b1;
      occ_q      <= 2'd0;
    end else begin
      down_vld_q <= down_vld_d;
      skid_vld_q <= skid_vld_d;
      up_rdy_q   <= up_rdy_d;
      occ_q      <= occ_d;
    end
  end

  // Datapath steering: a word goes to the skid register only when main is occupied and stalled.
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (up_xfer) main_d = up_data;
      end
      StBusy: begin
        if (up_xfer) begin
          if (down_rdy) begin
            main_d = up_data;
          end else begin
            skid_d = up_data;
          end
        end
      end
      StFull: begin
        if (down_rdy) main_d = skid_q;
      end
      default: begin
        main_d = main_q;
        skid_d = skid_q;
      end
    endcase
  end

  // Data registers are not reset: their contents are qualified by the valid flops.
  always_ff @(posedge clk) begin
    main_q <= main_d;
    skid_q <= skid_d;
  end

  assign up_rdy    = up_rdy_q;
  assign down_vld  = down_vld_q;
  assign down_data = main_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_fcb_3_skid_buffer_full_perf_no_comb_path.sv
// Testbench for the skid-buffer stage. Expected values come from a queue model with room for two words.
// Inputs are driven and outputs are sampled on the falling edge, away from the active clock edge.
module tb_fcb_3_skid_buffer_full_perf_no_comb_path;

  logic       clk;
  logic       rst_n;
  logic       up_vld;
  logic       up_rdy;
  logic [7:0] up_data;
  logic       down_vld;
  logic       down_rdy;
  logic [7:0] down_data;
  logic [1:0] occupancy;

  int vectors;
  int miscompares;

  logic [7:0] model_q[$];
  logic [7:0] out_log[$];

  fcb_3_skid_buffer_full_perf_no_comb_path #(
    .w(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_vld   (up_vld),
    .up_rdy   (up_rdy),
    .up_data  (up_data),
    .down_vld (down_vld),
    .down_rdy (down_rdy),
    .down_data(down_data),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Call this at a falling edge. It applies the inputs for one clock edge, updates the model and returns at the next falling edge.
  task automatic cycle(input logic rst, input logic v, input logic [7:0] d, input logic r);
    logic do_pop;
    logic do_push;
    rst_n    = rst;
    up_vld   = v;
    up_data  = d;
    down_rdy = r;
    do_pop   = rst && (model_q.size() > 0) && r;
    do_push  = rst && v && (model_q.size() < 2);
    if (rst && down_vld && r) out_log.push_back(down_data);
    @(posedge clk);
    if (!rst) begin
      model_q.delete();
    end else begin
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back(d);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'hAA, 1'b1);
    vectors++;
    if (down_vld !== 1'b0 || up_rdy !== 1'b1 || occupancy !== 2'd0) begin
      miscompares++;
      $display("FAIL reset: got vld=%b rdy=%b occ=%0d, want vld=0 rdy=1 occ=0",
               down_vld, up_rdy, occupancy);
    end
    cycle(1'b1, 1'b0, 8'h00, 1'b1);
    vectors++;
    if (down_vld !== 1'b0 || occupancy !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_idle: got vld=%b occ=%0d, want vld=0 occ=0", down_vld, occupancy);
    end
  endtask

  task automatic test_back_to_back();
    out_log.delete();
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b1, 1'b1, 8'(i), 1'b1);
      vectors++;
      if (up_rdy !== 1'b1 || down_vld !== 1'b1 || down_data !== 8'(i)) begin
        miscompares++;
        $display("FAIL b2b_step%0d: got rdy=%b vld=%b data=%h, want rdy=1 vld=1 data=%h",
                 i, up_rdy, down_vld, down_data, 8'(i));
      end
    end
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1);
    vectors++;
    if (out_log.size() != 16) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d words, want 16", out_log.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        vectors++;
        if (out_log[i] !== 8'(i + 1)) begin
          miscompares++;
          $display("FAIL b2b_order%0d: got %h want %h", i, out_log[i], 8'(i + 1));
        end
      end
    end
  endtask

  task automatic test_stall_fill();
    cycle(1'b1, 1'b1, 8'h11, 1'b0);
    vectors++;
    if (occupancy !== 2'd1 || down_data !== 8'h11 || up_rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL fill1: got occ=%0d data=%h rdy=%b, want occ=1 data=11 rdy=1",
               occupancy, down_data, up_rdy);
    end
    cycle(1'b1, 1'b1, 8'h22, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 8'h33, 1'b0);
      vectors++;
      if (occupancy !== 2'd2 || up_rdy !== 1'b0 || down_vld !== 1'b1 || down_data !== 8'h11) begin
        miscompares++;
        $display("FAIL fill_hold%0d: got occ=%0d rdy=%b vld=%b data=%h, want occ=2 rdy=0 vld=1 data=11",
                 i, occupancy, up_rdy, down_vld, down_data);
      end
    end
  endtask

  task automatic test_drain();
    logic [7:0] want[3];
    want[0] = 8'h11;
    want[1] = 8'h22;
    want[2] = 8'h33;
    out_log.delete();
    cycle(1'b1, 1'b1, 8'h33, 1'b1);
    vectors++;
    if (up_rdy !== 1'b1 || down_data !== 8'h22) begin
      miscompares++;
      $display("FAIL drain_rdy: got rdy=%b data=%h, want rdy=1 data=22", up_rdy, down_data);
    end
    cycle(1'b1, 1'b1, 8'h33, 1'b1);
    cycle(1'b1, 1'b0, 8'h00, 1'b1);
    vectors++;
    if (out_log.size() != 3 || down_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_count: got %0d words vld=%b, want 3 words vld=0", out_log.size(), down_vld);
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (out_log[i] !== want[i]) begin
          miscompares++;
          $display("FAIL drain_order%0d: got %h want %h", i, out_log[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_random_stress();
    logic       v;
    logic       r;
    logic [7:0] d;
    logic       rdy_before;
    logic       vld_before;
    logic [7:0] data_before;
    for (int n = 0; n < 10000; n++) begin
      vectors++;
      if (down_vld !== (model_q.size() > 0) || up_rdy !== (model_q.size() < 2) ||
          occupancy !== 2'(model_q.size()) || (down_vld === 1'b1 && down_data !== model_q[0])) begin
        miscompares++;
        $display("FAIL stress_cyc%0d: got vld=%b rdy=%b occ=%0d data=%h, want occ=%0d head=%h",
                 n, down_vld, up_rdy, occupancy, down_data, model_q.size(),
                 (model_q.size() > 0) ? model_q[0] : 8'h00);
      end
      vectors++;
      if (dut.skid_vld_q === 1'b1 && down_vld !== 1'b1) begin
        miscompares++;
        $display("FAIL stress_invariant%0d: got skid_vld=1 down_vld=%b, want down_vld=1", n, down_vld);
      end
      // Toggling the inputs in the middle of the cycle must leave every output unchanged.
      rdy_before  = up_rdy;
      vld_before  = down_vld;
      data_before = down_data;
      down_rdy = ~down_rdy;
      up_vld   = ~up_vld;
      up_data  = ~up_data;
      #1;
      vectors++;
      if (up_rdy !== rdy_before || down_vld !== vld_before || down_data !== data_before) begin
        miscompares++;
        $display("FAIL stress_comb%0d: got rdy=%b vld=%b data=%h, want rdy=%b vld=%b data=%h",
                 n, up_rdy, down_vld, down_data, rdy_before, vld_before, data_before);
      end
      v = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      cycle(1'b1, v, d, r);
    end
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_reset_mid_op();
    cycle(1'b1, 1'b1, 8'h5A, 1'b0);
    cycle(1'b1, 1'b1, 8'hA5, 1'b0);
    vectors++;
    if (occupancy !== 2'd2 || down_data !== 8'h5A) begin
      miscompares++;
      $display("FAIL midrst_full: got occ=%0d data=%h, want occ=2 data=5a", occupancy, down_data);
    end
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    vectors++;
    if (down_vld !== 1'b0 || up_rdy !== 1'b1 || occupancy !== 2'd0) begin
      miscompares++;
      $display("FAIL midrst: got vld=%b rdy=%b occ=%0d, want vld=0 rdy=1 occ=0",
               down_vld, up_rdy, occupancy);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 8'h00, 1'b1);
      vectors++;
      if (down_vld !== 1'b0) begin
        miscompares++;
        $display("FAIL midrst_leak%0d: got vld=%b data=%h, want vld=0", i, down_vld, down_data);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n    = 1'b0;
    up_vld   = 1'b1;
    up_data  = 8'hAA;
    down_rdy = 1'b1;
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_stall_fill();
    test_drain();
    test_random_stress();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fcb_3_skid_buffer_full_perf_no_comb_path.md
Name: fcb_3_skid_buffer_full_perf_no_comb_path

Overview:
- Valid/ready flow-control stage with a skid (double) buffer. Sustains one transfer per cycle with no combinational path in either direction.
- up_rdy is driven by a flop and does not depend on down_rdy. down_vld and down_data are driven by flops and do not depend on up_vld or up_data.
- Drop-in replacement for the half-performance single-register stage in long pipelines where the down_rdy to up_rdy path limits timing.

Parameters:
- w, 8, data width in bits; must be >= 1.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst_n  input  1  reset, synchronous, active-low.
- up_vld  input  1  upstream data valid.
- up_rdy  output  1  ready to upstream; flop output only.
- up_data  input  w  upstream data.
- down_vld  output  1  downstream data valid; flop output.
- down_rdy  input  1  downstream ready.
- down_data  output  w  downstream data; flop output.
- occupancy  output  2  number of words held (0, 1 or 2); flop-derived status.

Behaviour:
- Transfer rules:
  - Upstream transfer when up_vld & up_rdy at posedge clk.
  - Downstream transfer when down_vld & down_rdy at posedge clk.
- Storage:
  - Main register (down_data, down_vld) plus one skid register (skid_data, skid_vld).
  - up_rdy = ~skid_vld, taken directly from the flop.
- Reset (rst_n = 0 at a posedge):
  - down_vld = 0, skid_vld = 0, up_rdy = 1, occupancy = 0.
  - Data registers are not reset; down_data is don't-care while down_vld = 0.
  - Reset mid-operation discards all held words. No downstream transfer is reported in the reset cycle.
  - Upstream inputs are ignored while rst_n = 0.
- States (occupancy):
  - EMPTY (0): down_vld = 0, up_rdy = 1.
  - BUSY (1): down_vld = 1, up_rdy = 1.
  - FULL (2): down_vld = 1, up_rdy = 0.
- Transitions:
  - EMPTY, up_vld -> BUSY; main <= up_data.
  - EMPTY, no up_vld -> EMPTY.
  - BUSY, up_vld & down_rdy -> BUSY; main <= up_data (simultaneous in/out).
  - BUSY, up_vld & ~down_rdy -> FULL; skid <= up_data; main holds.
  - BUSY, ~up_vld & down_rdy -> EMPTY.
  - BUSY, neither -> BUSY; hold.
  - FULL, down_rdy -> BUSY; main <= skid; skid_vld <= 0. up_vld is ignored because up_rdy = 0.
  - FULL, ~down_rdy -> FULL; hold both.
- Latency and throughput:
  - A word accepted at edge N is visible on down_data after edge N; it can transfer at edge N+1 at the earliest.
  - Throughput is 1 word/cycle with down_rdy held high.
- Ordering: strict FIFO order; no loss, no duplication.
- AXI-style stability: while down_vld = 1 & ~down_rdy, down_vld and down_data must not change.
- Upstream protocol expectation: upstream keeps up_vld and up_data stable while up_vld & ~up_rdy. The block does not check this.
- Invariant: skid_vld implies down_vld. Illegal encodings are unreachable; the bench asserts the invariant.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles with up_vld = 1, up_data = 8'hAA -> down_vld = 0, up_rdy = 1, occupancy = 0. No transfer occurs.
- Back-to-back stream: send 8'h01..8'h10 on consecutive cycles with down_rdy = 1 -> 16 words out in order, one per cycle, first word 1 cycle after its acceptance. up_rdy never drops.
- Stall fill: with down_rdy = 0, offer 8'h11, 8'h22, 8'h33 -> 11 and 22 accepted, occupancy reaches 2, up_rdy = 0. 33 is held upstream. down_data = 11 stays stable.
- Drain after stall: from the FULL state above, raise down_rdy -> outputs 11, 22, 33 on consecutive cycles. up_rdy rises the cycle after 11 transfers.
- Random stress: randomise up_vld and down_rdy at 50%/50% over 10k cycles against a scoreboard queue -> zero mismatches, invariant holds, and no comb dependency (up_rdy is unchanged when down_rdy toggles mid-cycle).
- Reset mid-operation: in the FULL state with 8'h5A and 8'hA5 held, pulse rst_n = 0 for 1 cycle -> down_vld = 0, up_rdy = 1, occupancy = 0. Neither held word ever appears downstream.
